fpu_normalize_round: RTL and testbench
======================================

Name: fpu_normalize_round

Overview:
- Multicycle post-add stage that consumes the raw aligned mantissa sum and exponent from the FPU add datapath.
- Normalizes iteratively, one bit per cycle, and rounds to nearest-even.
- Checks overflow, underflow and zero, then packs a single- or half-precision result for register writeback.
- Sits between the mantissa adder and the multicycle controller's FPU writeback.

Parameters:
- MANT_W, 28, raw mantissa width: bit27 carry, bit26 hidden, bits25:3 fraction, bit2 guard, bit1 round, bit0 sticky.
- EXP_W, 10, internal exponent register width. Unsigned, with headroom for +1 and underflow detection.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start  input  1  accept operand; sampled only in IDLE
- single  input  1  1 = single precision (bias 127), 0 = half precision (bias 15)
- sign_in  input  1  sign of the unnormalized sum
- exp_in  input  8  biased exponent of the larger operand
- mant_in  input  MANT_W  raw sum, layout as in MANT_W
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse when result is valid
- result  output  32  packed result; half results are zero-extended in [15:0]
- overflow  output  1  result saturated to infinity
- underflow  output  1  result flushed to zero
- zero  output  1  exact zero result

Behaviour:
- Reset (asynchronous): state IDLE; busy=0, done=0, result=0, overflow/underflow/zero=0. Reset mid-operation aborts the operation with no done pulse.
- start while busy is ignored. Inputs are captured into internal registers on the accepting edge.
- Half-precision field layout in mant_in: fraction = [25:16], guard = [15], round = [14], sticky = OR of [13:0].
- FSM: IDLE -> NORM -> ROUND -> OUT -> IDLE.
- NORM, checks in priority order each cycle:
  - mant == 0: set zero; result = +0 (sign forced 0); go OUT.
  - mant[27] = 1: shift right 1; sticky |= shifted-out bit; exp+1; go ROUND.
  - mant[26] = 0 and exp > 1: shift left 1; exp-1; stay in NORM.
  - mant[26] = 0 and exp <= 1: flush. result = {sign, zeros}; underflow = 1; go OUT. Denormals are not produced.
  - Otherwise: go ROUND.
- ROUND:
  - Round increment = G & (R | S | LSB), using the per-format G/R/S/LSB positions.
  - Increment adds 1 at the LSB position (bit3 single, bit16 half).
  - If the increment carries into bit27: shift right 1, exp+1.
  - If exp >= 255 (single) or 31 (half): result = ±infinity (exp all ones, fraction 0); overflow = 1.
  - Go OUT.
- OUT:
  - Register result: single = {sign, exp[7:0], mant[25:3]}; half = {16'h0, sign, exp[4:0], mant[25:16]}.
  - done = 1 for exactly this cycle. Flags are valid with done.
  - Return to IDLE.
- Latency:
  - start sampled at edge E0; done high after edge E(2 + k), where k = number of left shifts (0..26).
  - Right shift and zero take no extra cycles.
  - busy is high from E0 until the edge that asserts done, then low while done is high.
- result and flags hold their values until the next done or reset. Flags are cleared at each start acceptance.
- exp_in = 0 with a nonzero mantissa follows the flush rule.

Test Plan:
- single=1, exp_in=0x7F, mant_in=1<<26 -> done 2 edges after start; result=0x3F800000; all flags 0.
- single=1, exp_in=0x7F, mant_in=1<<27 -> result=0x40000000, latency 2.
- mant_in=1<<23, exp_in=0x82 -> 3 left shifts; result=0x3F800000; done 5 edges after start; busy high throughout.
- Rounding, both with exp_in=0x7F:
  - mant_in=(1<<26)|(1<<2) (tie, LSB=0) -> 0x3F800000.
  - mant_in=(1<<26)|(1<<3)|(1<<2) (tie, LSB=1) -> 0x3F800002.
- Boundary results:
  - exp_in=0xFE, mant_in=1<<27 -> 0x7F800000, overflow=1.
  - mant_in=0 -> 0x00000000, zero=1.
  - mant_in=1<<20, exp_in=2 -> underflow=1, result=0x00000000.
- Half and control:
  - single=0, exp_in=15, mant_in=1<<26 -> result=0x00003C00.
  - Second start pulsed while busy -> ignored.
  - reset asserted in NORM -> busy=0 and no done pulse; next start completes normally.

Source files
------------

// File: rtl/fpu_normalize_round.sv
// Post-add normalize/round stage for the FPU add datapath.
// Takes the raw aligned mantissa sum and the larger operand's exponent,
// normalizes one bit per cycle, rounds to nearest-even, checks
// overflow/underflow/zero and packs a single or half precision result.
//
// Raw mantissa layout (MANT_W = 28):
//   [27] carry, [26] hidden, [25:3] single fraction, [2] G, [1] R, [0] S
//   half: fraction [25:16], G [15], R [14], S = |[13:0]
//
// Zero and flush outcomes found in NORM are recorded as pending and
// packed on the following edge. They take the same path to the done cycle
// as a normal result, so all outcomes share the 2 + k latency.
module fpu_normalize_round #(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              single,
  input  logic              sign_in,
  input  logic [7:0]        exp_in,
  input  logic [MANT_W-1:0] mant_in,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow,
  output logic              zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [MANT_W-1:0] INC_SINGLE = MANT_W'(32'h0000_0008);
  localparam logic [MANT_W-1:0] INC_HALF   = MANT_W'(32'h0001_0000);
  localparam logic [EXP_W-1:0]  EXP_ONE    = EXP_W'(1);
  localparam logic [EXP_W-1:0]  EXP_MAX_S  = EXP_W'(255);
  localparam logic [EXP_W-1:0]  EXP_MAX_H  = EXP_W'(31);

  state_t            state_reg;
  logic              single_reg;
  logic              sign_reg;
  logic [EXP_W-1:0]  exp_reg;
  logic [MANT_W-1:0] mant_reg;
  logic              zero_pend_reg;
  logic              flush_pend_reg;

  // Rounding datapath signals, evaluated from the normalized mantissa
  logic              guard_bit;
  logic              round_bit;
  logic              sticky_bit;
  logic              lsb_bit;
  logic              round_inc;
  logic [MANT_W-1:0] mant_sum;
  logic [MANT_W-1:0] mant_rnd;
  logic [EXP_W-1:0]  exp_rnd;
  logic              exp_ovf;
  logic [31:0]       packed_norm;
  logic [31:0]       packed_inf;
  logic [31:0]       packed_flush;

  // Right shift by one, folding the dropped bit into sticky
  logic [MANT_W-1:0] mant_shr;
  assign mant_shr = {1'b0, mant_reg[MANT_W-1:2], mant_reg[1] | mant_reg[0]};

  // Round to nearest-even at the format's LSB, then renormalize on carry-out
  always_comb begin
    guard_bit  = single_reg ? mant_reg[2] : mant_reg[15];
    round_bit  = single_reg ? mant_reg[1] : mant_reg[14];
    sticky_bit = single_reg ? mant_reg[0] : (|mant_reg[13:0]);
    lsb_bit    = single_reg ? mant_reg[3] : mant_reg[16];
    round_inc  = guard_bit & (round_bit | sticky_bit | lsb_bit);
    mant_sum   = mant_reg + (round_inc ? (single_reg ? INC_SINGLE : INC_HALF) : '0);
    mant_rnd   = mant_sum;
    exp_rnd    = exp_reg;
    if (mant_sum[MANT_W-1]) begin
      mant_rnd = {1'b0, mant_sum[MANT_W-1:1]};
      exp_rnd  = exp_reg + EXP_ONE;
    end
    exp_ovf = single_reg ? (exp_rnd >= EXP_MAX_S) : (exp_rnd >= EXP_MAX_H);
  end

  // Result packing for the normal, infinity and flush-to-zero outcomes
  always_comb begin
    if (single_reg) begin
      packed_norm  = {sign_reg, exp_rnd[7:0], mant_rnd[25:3]};
      packed_inf   = {sign_reg, 8'hFF, 23'h0};
      packed_flush = {sign_reg, 31'h0};
    end else begin
      packed_norm  = {16'h0, sign_reg, exp_rnd[4:0], mant_rnd[25:16]};
      packed_inf   = {16'h0, sign_reg, 5'h1F, 10'h0};
      packed_flush = {16'h0, sign_reg, 15'h0};
    end
  end

  // Bits of the rounded mantissa that never reach the packed result
  logic unused_rnd_bits;
  assign unused_rnd_bits = ^{mant_rnd[MANT_W-1:MANT_W-2], mant_rnd[2:0]};

  // Control FSM with registered busy/done/result/flag outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      single_reg     <= 1'b0;
      sign_reg       <= 1'b0;
      exp_reg        <= '0;
      mant_reg       <= '0;
      zero_pend_reg  <= 1'b0;
      flush_pend_reg <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      result         <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
      zero           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            single_reg     <= single;
            sign_reg       <= sign_in;
            exp_reg        <= {{(EXP_W-8){1'b0}}, exp_in};
            mant_reg       <= mant_in;
            zero_pend_reg  <= 1'b0;
            flush_pend_reg <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
            zero           <= 1'b0;
            busy           <= 1'b1;
            state_reg      <= NORM;
          end
        end

        NORM: begin
          if (mant_reg == '0) begin
            zero_pend_reg <= 1'b1;
            state_reg     <= ROUND;
          end else if (mant_reg[MANT_W-1]) begin
            mant_reg  <= mant_shr;
            exp_reg   <= exp_reg + EXP_ONE;
            state_reg <= ROUND;
          end else if (!mant_reg[MANT_W-2] && (exp_reg > EXP_ONE)) begin
            mant_reg <= {mant_reg[MANT_W-2:0], 1'b0};
            exp_reg  <= exp_reg - EXP_ONE;
          end else if (!mant_reg[MANT_W-2]) begin
            // Exponent exhausted before the hidden bit surfaced: no denormals
            flush_pend_reg <= 1'b1;
            state_reg      <= ROUND;
          end else begin
            state_reg <= ROUND;
          end
        end

        ROUND: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          state_reg <= OUT;
          if (zero_pend_reg) begin
            result <= '0;
            zero   <= 1'b1;
          end else if (flush_pend_reg) begin
            result    <= packed_flush;
            underflow <= 1'b1;
          end else if (exp_ovf) begin
            result   <= packed_inf;
            overflow <= 1'b1;
          end else begin
            result <= packed_norm;
          end
        end

        OUT: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Scoreboard bench for fpu_normalize_round: each operation pushes its
// expected result, flags and latency; a negedge monitor pops on done.
module tb_fpu_normalize_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        single;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [27:0] mant_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        zero;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit in_flight    = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        zr;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb[$];

  fpu_normalize_round #(.MANT_W(28), .EXP_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .single    (single),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Monitor: busy profile while an operation is in flight, scoreboard pop on done
  always @(negedge clk) begin
    if (in_flight) begin
      if (done) check_eq("busy_low_at_done", 32'(busy), 32'd0);
      else      check_eq("busy_high", 32'(busy), 32'd1);
    end
    if (done) begin
      in_flight = 1'b0;
      if (sb.size() == 0) begin
        check_eq("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t it;
        it = sb.pop_front();
        check_eq("result", result, it.res);
        check_eq("overflow", 32'(overflow), 32'(it.ovf));
        check_eq("underflow", 32'(underflow), 32'(it.unf));
        check_eq("zero", 32'(zero), 32'(it.zr));
        check_eq("latency", 32'(cyc - it.issue), 32'(it.lat));
        $display("[TB] done result=0x%08h ovf=%0b unf=%0b zero=%0b latency=%0d",
                 result, overflow, underflow, zero, cyc - it.issue);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check_eq("timeout", 32'd1, 32'd0);
      sb.delete();
      in_flight = 1'b0;
    end
    @(negedge clk);
  endtask

  // Drive one operation; optionally pulse a second, different start while busy
  task automatic run_op(input logic s, input logic sg, input logic [7:0] e,
                        input logic [27:0] m, input logic [31:0] r,
                        input logic o, input logic u, input logic z,
                        input int lat, input bit extra_start);
    exp_t it;
    @(negedge clk);
    single  = s;
    sign_in = sg;
    exp_in  = e;
    mant_in = m;
    start   = 1'b1;
    it.res = r; it.ovf = o; it.unf = u; it.zr = z;
    it.lat = lat; it.issue = cyc + 1;
    sb.push_back(it);
    @(posedge clk);
    in_flight = 1'b1;
    @(negedge clk);
    if (extra_start) begin
      single  = ~s;
      sign_in = ~sg;
      exp_in  = 8'h10;
      mant_in = 28'h0;
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    check_eq("result_hold", result, r);
    check_eq("flags_hold", {29'd0, overflow, underflow, zero}, {29'd0, o, u, z});
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    single  = 1'b1;
    sign_in = 1'b0;
    exp_in  = 8'h0;
    mant_in = 28'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_flags", {29'd0, overflow, underflow, zero}, 32'd0);
    reset = 1'b0;

    //       s     sg    exp    mant                                   result         o     u     z    lat
    run_op(1'b1, 1'b0, 8'h7F, 28'd1 << 26,                           32'h3F800000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b1, 1'b0, 8'h7F, 28'd1 << 27,                           32'h40000000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b1, 1'b0, 8'h82, 28'd1 << 23,                           32'h3F800000, 1'b0, 1'b0, 1'b0, 5, 1'b0);
    run_op(1'b1, 1'b0, 8'h7F, (28'd1 << 26) | (28'd1 << 2),          32'h3F800000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b1, 1'b0, 8'h7F, (28'd1 << 26) | (28'd1 << 3) | (28'd1 << 2), 32'h3F800002, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b1, 1'b0, 8'hFE, 28'd1 << 27,                           32'h7F800000, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b1, 1'b1, 8'h7F, 28'd0,                                 32'h00000000, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    run_op(1'b1, 1'b0, 8'h02, 28'd1 << 20,                           32'h00000000, 1'b0, 1'b1, 1'b0, 3, 1'b0);
    run_op(1'b0, 1'b0, 8'd15, 28'd1 << 26,                           32'h00003C00, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b0, 1'b0, 8'd15, (28'd1 << 26) | (28'd1 << 15) | (28'd1 << 14), 32'h00003C01, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b0, 1'b0, 8'd15, (28'd1 << 26) | (28'd1 << 15) | 28'd1, 32'h00003C01, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b0, 1'b0, 8'd15, (28'd1 << 26) | (28'd1 << 15),         32'h00003C00, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b1, 1'b1, 8'h80, 28'd1 << 26,                           32'hC0000000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b1, 1'b0, 8'h7F, 28'h7FFFFFF,                           32'h40000000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b1, 1'b0, 8'hFE, 28'h7FFFFFF,                           32'h7F800000, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b0, 1'b0, 8'd30, 28'd1 << 27,                           32'h00007C00, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b1, 1'b1, 8'h00, 28'd1 << 25,                           32'h80000000, 1'b0, 1'b1, 1'b0, 2, 1'b0);
    run_op(1'b0, 1'b1, 8'h01, 28'd1 << 25,                           32'h00008000, 1'b0, 1'b1, 1'b0, 2, 1'b0);
    run_op(1'b1, 1'b0, 8'h7F, 28'd1 << 26,                           32'h3F800000, 1'b0, 1'b0, 1'b0, 2, 1'b0);

    // Second start while busy must be ignored: one done, original operand
    run_op(1'b1, 1'b0, 8'h82, 28'd1 << 23,                           32'h3F800000, 1'b0, 1'b0, 1'b0, 5, 1'b1);
    repeat (8) @(negedge clk);
    check_eq("ignored_start_idle", 32'(busy), 32'd0);

    // Reset in NORM aborts without a done pulse
    @(negedge clk);
    single  = 1'b1;
    sign_in = 1'b0;
    exp_in  = 8'h82;
    mant_in = 28'd1 << 20;
    start   = 1'b1;
    @(posedge clk);
    in_flight = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_flight = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("abort_result", result, 32'd0);
    run_op(1'b1, 1'b0, 8'h7F, 28'd1 << 27,                           32'h40000000, 1'b0, 1'b0, 1'b0, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
